fd_dx_pipe_ctrl: RTL

//   Fetch/Decode and Decode/Execute pipeline latches with their hazard control for the 5-stage core.

---
 rtl/fd_dx_pipe_if.sv | 29 ++
 rtl/fd_dx_pipe_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fd_dx_pipe_if.sv
// Pipeline-control bus between the core datapath and the F/D + D/X latch controller.
// master: the datapath/hazard side that feeds fetch data and hazard inputs.
// slave : the pipe controller that owns the latches, PC enable and multdiv start.
interface fd_dx_pipe_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      f_pc;
    logic [31:0]      f_insn;
    logic             stall_lw;
    logic             flush;
    logic             md_ready;
    logic [31:0]      fd_pc;
    logic [31:0]      fd_insn;
    logic [31:0]      dx_pc;
    logic [31:0]      dx_insn;
    logic             pc_en;
    logic             md_start;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output f_pc, f_insn, stall_lw, flush, md_ready,
        input  fd_pc, fd_insn, dx_pc, dx_insn, pc_en, md_start, stall_cycles
    );

    modport slave (
        input  f_pc, f_insn, stall_lw, flush, md_ready,
        output fd_pc, fd_insn, dx_pc, dx_insn, pc_en, md_start, stall_cycles
    );
endinterface

// File: rtl/fd_dx_pipe_ctrl.sv
// F/D and D/X pipeline latches with load-use stall, branch flush and
// mul/div sequencing; also drives the PC write enable and a saturating
// stall-cycle counter for performance debug.
module fd_dx_pipe_ctrl #(
    parameter int          CNT_W = 16,
    parameter logic [31:0] NOP   = 32'd0
) (
    input  logic          clock,
    input  logic          reset,
    fd_dx_pipe_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_e;

    state_e           state_q,        state_d;
    logic [31:0]      fd_pc_q,        fd_pc_d;
    logic [31:0]      fd_insn_q,      fd_insn_d;
    logic [31:0]      dx_pc_q,        dx_pc_d;
    logic [31:0]      dx_insn_q,      dx_insn_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic             pc_en_s;
    logic             md_start_s;
    logic             is_md_s;

    // Detect a mul/div sitting in D/X (major opcode 0, ALU op mul or div).
    always_comb begin
        is_md_s = 1'b0;
        if (dx_insn_q[31:27] == 5'b00000 &&
            (dx_insn_q[6:2] == 5'b00110 || dx_insn_q[6:2] == 5'b00111)) begin
            is_md_s = 1'b1;
        end else begin
            is_md_s = 1'b0;
        end
    end

    // Next-state, latch updates and combinational PC enable / multdiv start.
    always_comb begin
        state_d        = state_q;
        fd_pc_d        = fd_pc_q;
        fd_insn_d      = fd_insn_q;
        dx_pc_d        = dx_pc_q;
        dx_insn_d      = dx_insn_q;
        stall_cycles_d = stall_cycles_q;
        pc_en_s        = 1'b0;
        md_start_s     = 1'b0;

        if (reset) begin
            state_d        = ST_RUN;
            fd_pc_d        = 32'd0;
            fd_insn_d      = 32'd0;
            dx_pc_d        = 32'd0;
            dx_insn_d      = 32'd0;
            stall_cycles_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.flush) begin
                        // Squash both wrong-path slots; the load-use stall is moot.
                        pc_en_s   = 1'b1;
                        fd_pc_d   = 32'd0;
                        fd_insn_d = NOP;
                        dx_pc_d   = 32'd0;
                        dx_insn_d = NOP;
                    end else if (is_md_s) begin
                        // Launch the multdiv once and freeze the front end.
                        md_start_s = 1'b1;
                        state_d    = ST_MD_WAIT;
                    end else if (bus.stall_lw) begin
                        // Hold the consumer in F/D and insert one bubble behind the load.
                        dx_pc_d   = 32'd0;
                        dx_insn_d = NOP;
                    end else begin
                        pc_en_s   = 1'b1;
                        fd_pc_d   = bus.f_pc;
                        fd_insn_d = bus.f_insn;
                        dx_pc_d   = fd_pc_q;
                        dx_insn_d = fd_insn_q;
                    end
                end
                ST_MD_WAIT: begin
                    if (bus.md_ready) begin
                        // Result is ready: the mul/div leaves D/X on this edge.
                        pc_en_s   = 1'b1;
                        fd_pc_d   = bus.f_pc;
                        fd_insn_d = bus.f_insn;
                        dx_pc_d   = fd_pc_q;
                        dx_insn_d = fd_insn_q;
                        state_d   = ST_RUN;
                    end else begin
                        pc_en_s = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase

            if (!pc_en_s && stall_cycles_q != {CNT_W{1'b1}}) begin
                stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles_d = stall_cycles_q;
            end
        end
    end

    // State and latch registers; reset is folded into the next-state logic.
    always_ff @(posedge clock) begin
        state_q        <= state_d;
        fd_pc_q        <= fd_pc_d;
        fd_insn_q      <= fd_insn_d;
        dx_pc_q        <= dx_pc_d;
        dx_insn_q      <= dx_insn_d;
        stall_cycles_q <= stall_cycles_d;
    end

    assign bus.fd_pc        = fd_pc_q;
    assign bus.fd_insn      = fd_insn_q;
    assign bus.dx_pc        = dx_pc_q;
    assign bus.dx_insn      = dx_insn_q;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.pc_en        = pc_en_s;
    assign bus.md_start     = md_start_s;

endmodule
